// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-bit-address accumulator CPU.
// Holds the machine widths used by the PC, ALU, memory and sequencer,
// the opcode encoding and the sequencer state encoding.
package cpu_pkg;

  localparam int ADDR_W = 5;  // PC / memory address width
  localparam int DATA_W = 8;  // instruction / data word width
  localparam int OP_W   = 3;  // opcode width; DATA_W-OP_W must equal ADDR_W

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the accumulator CPU.
// Owns the instruction register and sequences the PC, memory strobes and
// accumulator load.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   go         start/resume pulse, only looked at while halted
//   mem_rdata  memory read data, valid when mem_ready=1
//   mem_ready  memory handshake (read data valid / write accepted)
//   acc_zero   accumulator == 0
//   pc_en      PC increment enable
//   pc_load    PC parallel load
//   pc_data    PC load value (IR operand)
//   addr_sel   0: memory address = PC, 1: memory address = IR operand
//   mem_rd     memory read request
//   mem_wr     memory write request (data = accumulator)
//   acc_load   accumulator captures ALU result
//   alu_op     ALU operation (IR opcode)
//   halted     controller is in HALT
//   ir         instruction register
module cpu_sequencer #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int OP_W   = cpu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              acc_zero,
  output logic              pc_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_data,
  output logic              addr_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              acc_load,
  output logic [OP_W-1:0]   alu_op,
  output logic              halted,
  output logic [DATA_W-1:0] ir
);

  import cpu_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  opcode_e           opcode;

  assign opcode  = opcode_e'(ir_q[DATA_W-1 -: OP_W]);
  assign ir      = ir_q;
  assign pc_data = ir_q[ADDR_W-1:0];
  // The ALU is combinational, so the opcode can drive it in every state;
  // only acc_load decides when the result is captured.
  assign alu_op  = ir_q[DATA_W-1 -: OP_W];

  // State and IR registers. Because every strobe is decoded from state_q,
  // pulling rst low drops all strobes at once without waiting for clk.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && mem_ready) ir_q <= mem_rdata;
    end
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT:   if (go) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        unique case (opcode)
          OP_HLT:                         state_d = ST_HALT;
          OP_SKZ, OP_JMP:                 state_d = ST_FETCH;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: if (mem_ready) state_d = ST_WB;
          OP_STO:                         if (mem_ready) state_d = ST_FETCH;
        endcase
      end
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_HALT;
    endcase
  end

  // Output decode from state and IR. The only input-dependent strobes are
  // the fetch-cycle PC increment (taken together with the IR capture) and
  // the SKZ skip.
  always_comb begin
    halted   = 1'b0;
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_load = 1'b0;
    unique case (state_q)
      ST_HALT:   halted = 1'b1;
      ST_FETCH: begin
        mem_rd = 1'b1;
        pc_en  = mem_ready;
      end
      ST_DECODE: ;
      ST_EXEC: begin
        unique case (opcode)
          OP_HLT: ;
          OP_SKZ: pc_en = acc_zero;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
          end
          OP_STO: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
          end
          OP_JMP: pc_load = 1'b1;
        endcase
      end
      ST_WB: begin
        addr_sel = 1'b1;
        acc_load = 1'b1;
      end
      default: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: a cycle-by-cycle vector table covering the
// instruction classes, wait states and HALT/go behaviour, followed by
// hand-written asynchronous-reset sequences.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic       go;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       acc_zero;
  logic       pc_en, pc_load, addr_sel, mem_rd, mem_wr, acc_load, halted;
  logic [4:0] pc_data;
  logic [2:0] alu_op;
  logic [7:0] ir;

  cpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .acc_zero  (acc_zero),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .pc_data   (pc_data),
    .addr_sel  (addr_sel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .halted    (halted),
    .ir        (ir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe patterns {halted, pc_en, pc_load, addr_sel, mem_rd, mem_wr, acc_load}
  localparam logic [6:0] S_HALT  = 7'b1000000;
  localparam logic [6:0] S_IDLE  = 7'b0000000;
  localparam logic [6:0] S_FR    = 7'b0100100;  // fetch, data ready
  localparam logic [6:0] S_FW    = 7'b0000100;  // fetch, waiting
  localparam logic [6:0] S_EXRD  = 7'b0001100;  // operand read
  localparam logic [6:0] S_EXWR  = 7'b0001010;  // store
  localparam logic [6:0] S_JMP   = 7'b0010000;
  localparam logic [6:0] S_SKZ   = 7'b0100000;
  localparam logic [6:0] S_WB    = 7'b0001001;

  typedef struct {
    string      name;
    logic       go;
    logic [7:0] rdata;
    logic       ready;
    logic       az;
    logic [6:0] strobes;
    logic [7:0] ir;
  } vec_t;

  vec_t        vecs[$];
  logic [22:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Expected output word: strobes, alu_op, pc_data, ir.
  function automatic logic [22:0] mk(input logic [6:0] s, input logic [7:0] i);
    return {s, i[7:5], i[4:0], i};
  endfunction

  function automatic logic [22:0] actual();
    return {halted, pc_en, pc_load, addr_sel, mem_rd, mem_wr, acc_load,
            alu_op, pc_data, ir};
  endfunction

  task automatic add(input string name, input logic g, input logic [7:0] rd,
                     input logic rdy, input logic az, input logic [6:0] s,
                     input logic [7:0] i);
    vec_t v;
    v.name = name; v.go = g; v.rdata = rd; v.ready = rdy; v.az = az;
    v.strobes = s; v.ir = i;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] act,
                       input logic [22:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h (strobes=%b ir=%h) expected %h (strobes=%b ir=%h)",
               name, act, act[22:16], act[7:0], exp, exp[22:16], exp[7:0]);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, record the expectation and
  // compare shortly after, well before the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    go        = v.go;
    mem_rdata = v.rdata;
    mem_ready = v.ready;
    acc_zero  = v.az;
    exp_q.push_back(mk(v.strobes, v.ir));
    #2;
    check(v.name, actual(), exp_q.pop_front());
  endtask

  task automatic cyc(input string name, input logic g, input logic [7:0] rd,
                     input logic rdy, input logic az, input logic [6:0] s,
                     input logic [7:0] i);
    vec_t v;
    v.name = name; v.go = g; v.rdata = rd; v.ready = rdy; v.az = az;
    v.strobes = s; v.ir = i;
    apply(v);
  endtask

  // Pull reset mid-cycle and check the outputs before any clock edge.
  task automatic async_reset(input string name);
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(mk(S_HALT, 8'h00));
    check(name, actual(), exp_q.pop_front());
    @(negedge clk);
    go  = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; mem_rdata = '0; mem_ready = 1'b0; acc_zero = 1'b0;
    #12;
    check("reset_state", actual(), mk(S_HALT, 8'h00));
    @(negedge clk);
    rst = 1'b1;

    // ---------------- vector table ----------------
    add("idle_halt",     0, 8'h00, 0, 0, S_HALT, 8'h00);
    add("go_halt",       1, 8'h00, 0, 0, S_HALT, 8'h00);
    // LDA 20: 4 cycles
    add("lda_fetch",     0, 8'hB4, 1, 0, S_FR,   8'h00);
    add("lda_decode",    0, 8'h00, 0, 0, S_IDLE, 8'hB4);
    add("lda_exec",      0, 8'h07, 1, 0, S_EXRD, 8'hB4);
    add("lda_wb",        0, 8'h07, 1, 0, S_WB,   8'hB4);
    // JMP 25, with go ignored outside HALT
    add("jmp_fetch",     0, 8'hF9, 1, 0, S_FR,   8'hB4);
    add("jmp_decode",    1, 8'h00, 1, 0, S_IDLE, 8'hF9);
    add("jmp_exec",      1, 8'h00, 1, 0, S_JMP,  8'hF9);
    // SKZ with acc_zero=1 then acc_zero=0
    add("skz1_fetch",    0, 8'h20, 1, 1, S_FR,   8'hF9);
    add("skz1_decode",   0, 8'h00, 1, 1, S_IDLE, 8'h20);
    add("skz1_exec",     0, 8'h00, 1, 1, S_SKZ,  8'h20);
    add("skz0_fetch",    0, 8'h20, 1, 0, S_FR,   8'h20);
    add("skz0_decode",   0, 8'h00, 1, 0, S_IDLE, 8'h20);
    add("skz0_exec",     0, 8'h00, 1, 0, S_IDLE, 8'h20);
    // ADD 1 with one operand wait cycle
    add("add_fetch",     0, 8'h41, 1, 0, S_FR,   8'h20);
    add("add_decode",    0, 8'h00, 0, 0, S_IDLE, 8'h41);
    add("add_exec_wait", 0, 8'h00, 0, 0, S_EXRD, 8'h41);
    add("add_exec",      0, 8'h03, 1, 0, S_EXRD, 8'h41);
    add("add_wb",        0, 8'h00, 0, 0, S_WB,   8'h41);
    // STO 3 with two write wait cycles
    add("sto_fetch",     0, 8'hC3, 1, 0, S_FR,   8'h41);
    add("sto_decode",    0, 8'h00, 0, 0, S_IDLE, 8'hC3);
    add("sto_wait1",     0, 8'h00, 0, 0, S_EXWR, 8'hC3);
    add("sto_wait2",     1, 8'h00, 0, 0, S_EXWR, 8'hC3);
    add("sto_exec",      0, 8'h00, 1, 0, S_EXWR, 8'hC3);
    // HLT after a fetch wait, then hold HALT and resume
    add("hlt_fetch_wait",0, 8'hAA, 0, 0, S_FW,   8'hC3);
    add("hlt_fetch",     0, 8'h00, 1, 0, S_FR,   8'hC3);
    add("hlt_decode",    0, 8'h00, 0, 0, S_IDLE, 8'h00);
    add("hlt_exec",      0, 8'h00, 0, 0, S_IDLE, 8'h00);
    for (int i = 0; i < 10; i++)
      add("halt_hold",   0, 8'h00, 1, 0, S_HALT, 8'h00);
    add("halt_go",       1, 8'h00, 0, 0, S_HALT, 8'h00);
    add("resume_fetch",  0, 8'hE0, 1, 0, S_FR,   8'h00);
    add("resume_decode", 0, 8'h00, 1, 0, S_IDLE, 8'hE0);
    add("resume_exec",   0, 8'h00, 1, 0, S_JMP,  8'hE0);

    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- reset during a store wait ----------------
    cyc("rs_sto_fetch",  0, 8'hC3, 1, 0, S_FR,   8'hE0);
    cyc("rs_sto_decode", 0, 8'h00, 0, 0, S_IDLE, 8'hC3);
    cyc("rs_sto_wait",   0, 8'h00, 0, 0, S_EXWR, 8'hC3);
    async_reset("rs_sto_async");
    cyc("rs_sto_hold",   0, 8'h00, 1, 0, S_HALT, 8'h00);
    cyc("rs_sto_hold",   0, 8'h00, 1, 0, S_HALT, 8'h00);

    // ---------------- reset during a fetch wait ----------------
    cyc("rf_go",         1, 8'h00, 0, 0, S_HALT, 8'h00);
    cyc("rf_fetch_wait", 0, 8'h55, 0, 0, S_FW,   8'h00);
    async_reset("rf_async");
    cyc("rf_hold",       0, 8'h00, 1, 0, S_HALT, 8'h00);
    cyc("rf_hold",       0, 8'h00, 1, 0, S_HALT, 8'h00);
    cyc("rf_go",         1, 8'h00, 1, 0, S_HALT, 8'h00);
    cyc("rf_fetch",      0, 8'h7F, 1, 0, S_FR,   8'h00);
    cyc("rf_decode",     0, 8'h00, 0, 0, S_IDLE, 8'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
